// File: rtl/cp0_int_ctrl_pkg.sv
// Shared constants for the CP0 interrupt controller: register numbers,
// SR/Cause bit positions, handler vector and FSM state encoding.
`timescale 1ns/1ps
package cp0_int_ctrl_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CP0_ADDR_W = 5;
    localparam int unsigned HWINT_W    = 6;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [CP0_ADDR_W-1:0] CP0_SR    = 5'd12;
    localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE = 5'd13;
    localparam logic [CP0_ADDR_W-1:0] CP0_EPC   = 5'd14;
    localparam logic [CP0_ADDR_W-1:0] CP0_PRID  = 5'd15;

    // SR / Cause field positions
    localparam int unsigned IM_HI   = 15;
    localparam int unsigned IM_LO   = 10;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned IE_BIT  = 0;

    // Exception handler entry point loaded by the next-PC unit on intreq
    localparam logic [XLEN-1:0] HANDLER_VEC = 32'h0000_4180;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_GUARD   = 2'd2
    } cp0_state_e;

endpackage

// File: rtl/cp0_int_ctrl_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
// Ports: clk, rst (async active-high), din (raw lines), dout (synchronised).
`timescale 1ns/1ps
module int_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift chain; stage 0 is the metastability-catching flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: holds SR/Cause/EPC/PRId, synchronises hwint and
// asserts intreq at instruction boundaries to redirect to the handler.
// Ports:
//   clk, rst      clock / async active-high reset
//   pc_en         instruction boundary (PC loads at this edge)
//   pc_next       sequential next PC, captured into EPC on a take
//   hwint         raw level-sensitive interrupt lines
//   cp0_we/addr/din  mtc0 write port
//   eret          ERET executing this cycle
//   intreq        redirect request (Mealy, combinational)
//   epc, exl      EPC register and SR.EXL
//   cp0_dout      mfc0 read data, combinational from cp0_addr
`timescale 1ns/1ps
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID        = 32'h0000_2295,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_en,
    input  logic [XLEN-1:0]       pc_next,
    input  logic [HWINT_W-1:0]    hwint,
    input  logic                  cp0_we,
    input  logic [CP0_ADDR_W-1:0] cp0_addr,
    input  logic [XLEN-1:0]       cp0_din,
    input  logic                  eret,
    output logic                  intreq,
    output logic [XLEN-1:0]       epc,
    output logic                  exl,
    output logic [XLEN-1:0]       cp0_dout
);

    cp0_state_e           state_q;
    cp0_state_e           state_d;
    logic [HWINT_W-1:0]   ip;
    logic [HWINT_W-1:0]   sr_im_q;
    logic                 sr_ie_q;
    logic                 exl_q;
    logic [XLEN-1:0]      epc_q;
    logic                 pending;
    logic                 sr_wr;
    logic                 epc_wr;
    logic                 eret_take;

    int_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (HWINT_W)
    ) u_int_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (hwint),
        .dout (ip)
    );

    // Uses the registered (pre-write) SR so an mtc0 in the same cycle cannot
    // enable or mask the take it coincides with
    assign pending   = (|(ip & sr_im_q)) & sr_ie_q & ~exl_q;
    assign sr_wr     = cp0_we && (cp0_addr == CP0_SR);
    assign epc_wr    = cp0_we && (cp0_addr == CP0_EPC);
    assign eret_take = (state_q == ST_HANDLER) && eret && pc_en;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (intreq)    state_d = ST_HANDLER;
            ST_HANDLER: if (eret_take) state_d = ST_GUARD;
            ST_GUARD:   if (pc_en)     state_d = ST_RUN;
            default:                   state_d = ST_RUN;
        endcase
    end

    // Output logic: requests only in RUN and only on a boundary; GUARD lets
    // one post-ERET instruction retire before another take is possible
    always_comb begin
        intreq = 1'b0;
        if (state_q == ST_RUN) begin
            intreq = pending & pc_en;
        end
    end

    // SR: IM/IE software-writable; EXL set on take, cleared on ERET only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_im_q <= '0;
            sr_ie_q <= 1'b0;
            exl_q   <= 1'b0;
        end else begin
            if (sr_wr) begin
                sr_im_q <= cp0_din[IM_HI:IM_LO];
                sr_ie_q <= cp0_din[IE_BIT];
            end
            if (intreq) begin
                exl_q <= 1'b1;
            end else if (eret_take) begin
                exl_q <= 1'b0;
            end
        end
    end

    // EPC: a take overrides a coincident mtc0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= '0;
        end else if (intreq) begin
            epc_q <= pc_next;
        end else if (epc_wr) begin
            epc_q <= cp0_din;
        end
    end

    // mfc0 read mux
    always_comb begin
        cp0_dout = '0;
        case (cp0_addr)
            CP0_SR: begin
                cp0_dout[IM_HI:IM_LO] = sr_im_q;
                cp0_dout[EXL_BIT]     = exl_q;
                cp0_dout[IE_BIT]      = sr_ie_q;
            end
            CP0_CAUSE: cp0_dout[IM_HI:IM_LO] = ip;
            CP0_EPC:   cp0_dout = epc_q;
            CP0_PRID:  cp0_dout = PRID;
            default:   cp0_dout = '0;
        endcase
    end

    assign epc = epc_q;
    assign exl = exl_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Scoreboard bench for cp0_int_ctrl: expectations are queued as stimulus is
// driven and drained when the DUT outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_cp0_int_ctrl;

    localparam logic [31:0] PRID_V = 32'h0000_2295;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic [31:0] pc_next;
    logic [5:0]  hwint;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_din;
    logic        eret;
    logic        intreq;
    logic [31:0] epc;
    logic        exl;
    logic [31:0] cp0_dout;

    always #5 clk = ~clk;

    cp0_int_ctrl #(
        .PRID        (PRID_V),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .pc_en    (pc_en),
        .pc_next  (pc_next),
        .hwint    (hwint),
        .cp0_we   (cp0_we),
        .cp0_addr (cp0_addr),
        .cp0_din  (cp0_din),
        .eret     (eret),
        .intreq   (intreq),
        .epc      (epc),
        .exl      (exl),
        .cp0_dout (cp0_dout)
    );

    typedef enum int {S_INTREQ, S_EXL, S_EPC, S_DOUT} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_INTREQ: return {31'd0, intreq};
            S_EXL:    return {31'd0, exl};
            S_EPC:    return epc;
            default:  return cp0_dout;
        endcase
    endfunction

    task automatic push_exp(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        sb_drain();
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] v, input string tag);
        cp0_addr = addr;
        #1;
        push_exp(tag, S_DOUT, v);
        sb_drain();
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we   = 1'b1;
        cp0_addr = addr;
        cp0_din  = data;
        tick();
        cp0_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_en = 1'b0; pc_next = '0; hwint = '0;
        cp0_we = 1'b0; cp0_addr = 5'd15; cp0_din = '0; eret = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and register reads
        push_exp("rst_intreq", S_INTREQ, 32'd0);
        push_exp("rst_exl",    S_EXL,    32'd0);
        push_exp("rst_epc",    S_EPC,    32'd0);
        sample();
        rd(5'd15, PRID_V, "rst_prid");
        rd(5'd12, 32'd0,  "rst_sr");
        rd(5'd13, 32'd0,  "rst_cause");
        rd(5'd14, 32'd0,  "rst_epcreg");

        // Basic take: two synchroniser edges, then Mealy intreq
        tick();
        pc_en = 1'b1; pc_next = 32'h0000_3010;
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001;
        push_exp("take_pre", S_INTREQ, 32'd0);
        sample();
        tick();
        push_exp("take_sync1", S_INTREQ, 32'd0);
        sample();
        tick();
        push_exp("take_req", S_INTREQ, 32'd1);
        sample();
        tick();
        push_exp("take_post_req", S_INTREQ, 32'd0);
        push_exp("take_exl",      S_EXL,    32'd1);
        push_exp("take_epc",      S_EPC,    32'h0000_3010);
        sample();
        rd(5'd14, 32'h0000_3010, "take_rd_epc");
        rd(5'd13, 32'h0000_0400, "take_rd_cause");
        rd(5'd12, 32'h0000_0403, "take_rd_sr");

        // ERET guard with hwint still asserted
        tick();
        eret = 1'b1;
        push_exp("hdl_noreq", S_INTREQ, 32'd0);
        sample();
        tick();
        eret = 1'b0;
        push_exp("guard_exl",   S_EXL,    32'd0);
        push_exp("guard_noreq", S_INTREQ, 32'd0);
        sample();
        tick();
        // Second boundary retakes; collide with mtc0 EPC
        pc_next = 32'h0000_3020;
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_din = 32'hDEAD_BEEF;
        push_exp("guard_retake", S_INTREQ, 32'd1);
        sample();
        tick();
        cp0_we = 1'b0;
        push_exp("coll_epc", S_EPC, 32'h0000_3020);
        push_exp("coll_exl", S_EXL, 32'd1);
        sample();

        // Asynchronous reset while in HANDLER
        tick();
        #2;
        rst = 1'b1;
        #1;
        push_exp("arst_exl",    S_EXL,    32'd0);
        push_exp("arst_epc",    S_EPC,    32'd0);
        push_exp("arst_intreq", S_INTREQ, 32'd0);
        sb_drain();
        tick();
        rst = 1'b0;

        // Boundary wait: pc_en low for 5 cycles
        pc_en = 1'b0; pc_next = 32'h0000_5004;
        mtc0(5'd12, 32'h0000_0401);
        for (int i = 0; i < 5; i++) begin
            push_exp($sformatf("wait_noreq%0d", i), S_INTREQ, 32'd0);
            sample();
            tick();
        end
        pc_en = 1'b1;
        push_exp("wait_req", S_INTREQ, 32'd1);
        sample();
        tick();
        push_exp("wait_epc", S_EPC, 32'h0000_5004);
        push_exp("wait_exl", S_EXL, 32'd1);
        sample();

        // Masking: IE=0 with all IM, then IM=0 with IE=1
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hwint = 6'h3F; pc_en = 1'b1;
        mtc0(5'd12, 32'h0000_FC00);
        for (int i = 0; i < 20; i++) begin
            push_exp($sformatf("mask_ie%0d", i), S_INTREQ, 32'd0);
            sample();
            if (i == 2) rd(5'd13, 32'h0000_FC00, "mask_cause");
            tick();
        end
        mtc0(5'd12, 32'h0000_0001);
        for (int i = 0; i < 20; i++) begin
            push_exp($sformatf("mask_im%0d", i), S_INTREQ, 32'd0);
            sample();
            tick();
        end

        // EXL is not software-writable
        mtc0(5'd12, 32'h0000_0002);
        push_exp("exl_nowr", S_EXL, 32'd0);
        sample();
        rd(5'd12, 32'd0, "exl_nowr_sr");

        // Interrupt withdrawn before any boundary: nothing latched
        tick();
        pc_en = 1'b0; hwint = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("drop_hold%0d", i), S_INTREQ, 32'd0);
            sample();
            tick();
        end
        hwint = 6'b000000;
        tick(); tick(); tick();
        pc_en = 1'b1;
        push_exp("drop_noreq", S_INTREQ, 32'd0);
        sample();
        tick();
        push_exp("drop_exl", S_EXL, 32'd0);
        sample();

        // Take coinciding with mtc0 SR: new IM/IE plus EXL
        tick();
        hwint = 6'b000001;
        tick(); tick();
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_din = 32'h0000_0800;
        push_exp("srcoll_req", S_INTREQ, 32'd1);
        sample();
        tick();
        cp0_we = 1'b0;
        push_exp("srcoll_exl",   S_EXL,    32'd1);
        push_exp("srcoll_noreq", S_INTREQ, 32'd0);
        sample();
        rd(5'd12, 32'h0000_0802, "srcoll_sr");
        rd(5'd3,  32'd0,         "unmapped_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
